uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised asynchronous-serial transmitter. Successor to the fixed 8N1 single-byte transmitter.
- Adds configurable data width, stop bits and baud divisor, a valid/ready input handshake, and an internal FIFO for back-to-back frames.
- Sits between a byte-producing core (loopback, command encoder) and the board TX pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate. BAUD_DIV = CLK_FREQ/BAUD, integer division; 5208 at the defaults.
- DATA_BITS, 8: payload bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- FIFO_DEPTH, 4: entries in the input FIFO. Power of 2, at least 2.

Ports:
- sys_clk  in  1  system clock. Only clock in the block.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_BITS  payload word. Bit 0 is sent first.
- data_valid  in  1  producer offers data_in this cycle.
- data_ready  out  1  FIFO can accept. Equals !full.
- parity_odd  in  1  1 = odd parity, 0 = even. Ignored unless UART_TX_PARITY_EN is defined.
- tx  out  1  serial line. Idles high. Registered output.
- busy  out  1  a frame is on the line, or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: tx=1, busy=0, fifo_level=0, data_ready=1. FIFO is emptied, FSM goes to IDLE, all counters are 0.
- A reset asserted mid-frame aborts the frame immediately. The async reset drives tx high with no partial stop bit.
- Handshake: a word is written on a rising edge with data_valid && data_ready. data_ready is combinational from the registered count, so a full FIFO accepts nothing, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO: the level is unchanged.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: when the FIFO is non-empty. The same edge pops the head into the shift register, latches parity_odd, and clears the baud and bit counters.
- Each state holds for exactly BAUD_DIV clocks per bit. The baud counter runs 0..BAUD_DIV-1 and wraps. Its width is $clog2(BAUD_DIV).
- START: drives tx 0 for one bit time.
- DATA: drives DATA_BITS bits, LSB first, by shifting right.
- PARITY: entered only when the macro is defined. Drives ^payload when even, ~^payload when odd.
- STOP: drives tx 1 for STOP_BITS bit times.
- End of the last stop bit: go to START if the FIFO is non-empty, with no idle gap and the pop on the same edge. Otherwise go to IDLE.
- tx is registered from the state and shift-register LSB. It falls on the 2nd rising edge after the accepting edge when the block was idle and the FIFO empty.
- busy = (state != IDLE) || (fifo_level != 0).
- Frame length in bit times: 1 + DATA_BITS + P + STOP_BITS, where P = 1 with parity, else 0.
- FIFO pointers wrap modulo FIFO_DEPTH. The level counter saturates at neither end by construction.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP; parity_odd is used.
- Undefined: DATA goes directly to STOP, parity_odd is unconnected internally, and the frame is one bit shorter.

Decomposition:
- Package uart_pkg:
  - FSM state typedef (IDLE/START/DATA/PARITY/STOP).
  - function baud_div(clk_freq, baud).
  - localparam IDLE_LEVEL = 1'b1.
- Sub-module uart_tx_fifo, a synchronous FIFO. Parameters WIDTH and DEPTH. Ports wr_en, din, rd_en, dout, full, empty, level.
- The top holds the baud counter, bit counter, shift register and FSM.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1, so BAUD_DIV=16.
- Single word: push 0x55 (8N1, parity off) -> tx low at the 2nd edge after accept; then 0,1,0,1,0,1,0,1,0,1 for 16 clocks each; busy drops after 160 clocks of line activity.
- Burst: hold data_valid with 0x00,0xFF,0xA5,0x3C,0x81,0x7E, FIFO_DEPTH=4 -> data_ready falls once fifo_level=4 after 5 words are accepted; frames are contiguous with no idle high between stop and start; bytes are received in order.
- Parity (macro on): 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> 0; frame is 11 bits (176 clocks).
- Stop bits: STOP_BITS=2, DATA_BITS=7, push 0x7F -> 0, seven 1s, then tx high for 32 clocks before the next start bit from a queued 0x01.
- Reset mid-frame: deassert sys_rst_n during data bit 3 with 2 words queued -> tx=1, busy=0, fifo_level=0, data_ready=1 without a clock edge; after release the line stays idle.
- Full-FIFO collision: FIFO full, data_valid held while the FSM pops -> no write that cycle; level goes 4→3 and data_ready rises next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, idle level and baud divisor helper for the UART transmitter
//
// Contents:
//   uart_state_t      3-bit FSM state type
//   ST_IDLE..ST_STOP  state encodings (plain constants so older tools and netlists can use them)
//   IDLE_LEVEL        line level when nothing is being sent
//   baud_div()        clocks per bit time, integer division of clock by line rate
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO feeding the UART transmitter
//
// Parameters:
//   WIDTH  word width
//   DEPTH  number of entries, power of 2, at least 2
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, empties the FIFO
//   wr_en  in   write request, ignored while full
//   din    in   write data
//   rd_en  in   read request, ignored while empty
//   dout   out  head of the FIFO, valid whenever empty is low
//   full   out  level == DEPTH
//   empty  out  level == 0
//   level  out  current occupancy 0..DEPTH
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // full/empty come from the registered level, so a full FIFO refuses a
    // write even when a read frees a slot on the same edge.
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised asynchronous-serial transmitter with input FIFO
//
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit between data and stop bits).
//
// Parameters:
//   CLK_FREQ    system clock in Hz
//   BAUD        line rate; bit time is CLK_FREQ/BAUD clocks
//   DATA_BITS   payload bits per frame, 5..9
//   STOP_BITS   stop bits per frame, 1 or 2
//   FIFO_DEPTH  input FIFO entries, power of 2, at least 2
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   data_in     in   payload word, bit 0 sent first
//   data_valid  in   producer offers data_in
//   data_ready  out  FIFO not full
//   parity_odd  in   1 = odd parity, 0 = even (used only with UART_TX_PARITY_EN)
//   tx          out  registered serial line, idles high
//   busy        out  frame in flight or FIFO non-empty
//   fifo_level  out  FIFO occupancy
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          parity_odd,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W    = $clog2(DATA_BITS);

    uart_state_t            state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   baud_tick;
    logic                   last_data;
    logic                   last_stop;
    logic                   pop;
    logic                   tx_next;

    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .wr_en (data_valid),
        .din   (data_in),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign data_ready = !fifo_full;
    assign busy       = (state != ST_IDLE) || (fifo_level != '0);

    assign baud_tick = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

    // A new frame starts either from idle or straight out of the last stop
    // bit, so back-to-back words leave no idle gap on the line.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) ||
                  ((state == ST_STOP) && baud_tick && last_stop));

`ifdef UART_TX_PARITY_EN
    logic par_bit;

    // Parity is fixed at the moment the word leaves the FIFO.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            par_bit <= 1'b0;
        end else if (pop) begin
            par_bit <= (^fifo_dout) ^ parity_odd;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Line level for the bit currently being timed; registered into tx so
    // the pin changes one clock after the state does.
    always_comb begin
        tx_next = IDLE_LEVEL;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = par_bit;
`endif
            ST_STOP:   tx_next = 1'b1;
            default:   tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= IDLE_LEVEL;
        end else begin
            tx <= tx_next;
            if (pop) begin
                state    <= ST_START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= fifo_dout;
            end else if (state != ST_IDLE) begin
                baud_cnt <= baud_tick ? '0 : baud_cnt + CNT_W'(1);
                if (baud_tick) begin
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                        ST_DATA: begin
                            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                            if (last_data) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                        ST_PARITY: begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                        end
                        ST_STOP: begin
                            // The queued-word case was taken by pop above.
                            if (last_stop) begin
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                        default: begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - randomized self-checking bench for uart_tx_param against a frame-level model
module tb_uart_tx_param;

    localparam int BD    = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DB0 = 8;
    localparam int SB0 = 1;
    localparam int DB1 = 7;
    localparam int SB1 = 2;
    localparam int FL0 = 1 + DB0 + P + SB0;
    localparam int FL1 = 1 + DB1 + P + SB1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din0  = '0;
    logic [6:0] din1  = '0;
    logic       val0  = 1'b0;
    logic       val1  = 1'b0;
    logic       par0  = 1'b0;
    logic       par1  = 1'b0;
    logic       tx0, tx1, busy0, busy1, rdy0, rdy1;
    logic [2:0] lvl0, lvl1;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(DB0), .STOP_BITS(SB0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .data_in(din0), .data_valid(val0), .data_ready(rdy0),
        .parity_odd(par0), .tx(tx0), .busy(busy0), .fifo_level(lvl0));

    uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(DB1), .STOP_BITS(SB1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .data_in(din1), .data_valid(val1), .data_ready(rdy1),
        .parity_odd(par1), .tx(tx1), .busy(busy1), .fifo_level(lvl1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame-level model: a word queue plus "which clock of which frame".
    int          m_q    [2][DEPTH];
    int          m_head [2];
    int          m_cnt  [2];
    bit          m_in   [2];
    int          m_k    [2];
    logic [15:0] m_bits [2];
    int          m_len  [2];
    logic        m_tx   [2];

    // Line decoder working from the DUT's tx samples.
    int rx_cnt  [2];
    int rx_n    [2];
    int rx_log  [2][16];
    int rx_gap  [2][16];
    int rx_last [2];
    int rx_acc  [2];
    int rx_par  [2];

    int stx   [200];
    int sbusy [200];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int db_of(input int i);
        return (i == 0) ? DB0 : DB1;
    endfunction

    function automatic int sb_of(input int i);
        return (i == 0) ? SB0 : SB1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_head[i] = 0;
            m_cnt[i]  = 0;
            m_in[i]   = 0;
            m_k[i]    = 0;
            m_len[i]  = 0;
            m_bits[i] = '1;
            m_tx[i]   = 1'b1;
            rx_cnt[i] = -1;
        end
    endtask

    task automatic load_frame(input int i, input int w, input bit p);
        int db;
        int n;
        int mw;
        db = db_of(i);
        mw = w & ((1 << db) - 1);
        m_bits[i] = '0;
        for (int j = 0; j < db; j++) m_bits[i][1 + j] = mw[j];
        n = 1 + db;
        if (P == 1) begin
            m_bits[i][n] = (^mw) ^ p;
            n++;
        end
        for (int s = 0; s < sb_of(i); s++) begin
            m_bits[i][n] = 1'b1;
            n++;
        end
        m_len[i] = n;
    endtask

    // One rising edge of instance i, computed from pre-edge values.
    task automatic model_step(input int i, input bit v, input int w, input bit p);
        int   lvl;
        int   head_pre;
        bit   fr_end;
        logic ntx;
        lvl      = m_cnt[i];
        head_pre = m_head[i];
        ntx      = m_in[i] ? m_bits[i][m_k[i] / BD] : 1'b1;
        fr_end   = m_in[i] && (m_k[i] == m_len[i] * BD - 1);
        if (m_in[i] && !fr_end) begin
            m_k[i]++;
        end else if (lvl > 0) begin
            load_frame(i, m_q[i][head_pre], p);
            m_head[i] = (head_pre + 1) % DEPTH;
            m_cnt[i]--;
            m_in[i] = 1;
            m_k[i]  = 0;
        end else begin
            m_in[i] = 0;
        end
        if (v && lvl < DEPTH) begin
            m_q[i][(head_pre + lvl) % DEPTH] = w;
            m_cnt[i]++;
        end
        m_tx[i] = ntx;
    endtask

    task automatic rx_step(input int i, input logic t);
        int db;
        db = db_of(i);
        if (rx_cnt[i] < 0) begin
            if (t == 1'b0) begin
                rx_cnt[i] = 0;
                if (rx_n[i] < 16) rx_gap[i][rx_n[i]] = cyc - rx_last[i];
                rx_last[i] = cyc;
                rx_acc[i]  = 0;
            end
        end else begin
            rx_cnt[i]++;
            for (int j = 0; j < db; j++) begin
                if (rx_cnt[i] == 8 + 16 * (1 + j)) rx_acc[i] = rx_acc[i] | (int'(t) << j);
            end
            if (P == 1 && rx_cnt[i] == 8 + 16 * (1 + db)) rx_par[i] = int'(t);
            if (rx_cnt[i] == 8 + 16 * (1 + db + P)) begin
                if (rx_n[i] < 16) rx_log[i][rx_n[i]] = rx_acc[i];
                rx_n[i]++;
                rx_cnt[i] = -1;
            end
        end
    endtask

    task automatic compare(input int i, input logic t, input logic b, input logic r, input int l);
        chk($sformatf("tx[%0d]", i), int'(t), int'(m_tx[i]));
        chk($sformatf("busy[%0d]", i), int'(b), int'(m_in[i] || m_cnt[i] != 0));
        chk($sformatf("fifo_level[%0d]", i), l, m_cnt[i]);
        chk($sformatf("data_ready[%0d]", i), int'(r), int'(m_cnt[i] < DEPTH));
    endtask

    task automatic tick();
        model_step(0, val0, int'(din0), par0);
        model_step(1, val1, int'(din1), par1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare(0, tx0, busy0, rdy0, int'(lvl0));
        compare(1, tx1, busy1, rdy1, int'(lvl1));
        rx_step(0, tx0);
        rx_step(1, tx1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((m_in[0] || m_cnt[0] != 0 || m_in[1] || m_cnt[1] != 0) && g < 5000) begin
            tick();
            g++;
        end
        chk("wait_idle_bound", int'(g < 5000), 1);
        repeat (4) tick();
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_tx0"}, int'(tx0), 1);
        chk({tag, "_busy0"}, int'(busy0), 0);
        chk({tag, "_lvl0"}, int'(lvl0), 0);
        chk({tag, "_rdy0"}, int'(rdy0), 1);
        chk({tag, "_tx1"}, int'(tx1), 1);
        chk({tag, "_busy1"}, int'(busy1), 0);
        chk({tag, "_lvl1"}, int'(lvl1), 0);
        chk({tag, "_rdy1"}, int'(rdy1), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          words [6];
        int          idx;
        int          g;
        bit          acc;
        bit          full_seen;
        bit          coll_seen;
        logic [10:0] pat;

        words = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};
        model_reset();
        for (int i = 0; i < 2; i++) begin
            rx_n[i] = 0;
            rx_last[i] = 0;
            rx_par[i] = -1;
        end

        repeat (3) @(negedge clk);
        reset_literals("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word 0x55: tx pattern and busy timing relative to the accept edge.
        din0 = 8'h55;
        val0 = 1'b1;
        tick();
        val0 = 1'b0;
        for (int k = 1; k < 16 * FL0 + 4; k++) begin
            tick();
            stx[k]   = int'(tx0);
            sbusy[k] = int'(busy0);
        end
`ifdef UART_TX_PARITY_EN
        pat = 11'h4AA;
`else
        pat = 11'h2AA;
`endif
        chk("single_tx_before_fall", stx[1], 1);
        chk("single_tx_fall", stx[2], 0);
        for (int b = 0; b < FL0; b++) chk($sformatf("single_bit%0d", b), stx[10 + 16 * b], int'(pat[b]));
        chk("single_busy_last", sbusy[16 * FL0], 1);
        chk("single_busy_drop", sbusy[16 * FL0 + 1], 0);
        wait_idle();

        // Burst with held valid: fills the FIFO, then a pop while full.
        rx_n[0]   = 0;
        idx       = 0;
        g         = 0;
        full_seen = 0;
        coll_seen = 0;
        val0      = 1'b1;
        while (idx < 6 && g < 2000) begin
            din0 = 8'(words[idx]);
            acc  = (m_cnt[0] < DEPTH);
            tick();
            g++;
            if (acc) idx++;
            if (!full_seen && m_cnt[0] == DEPTH) begin
                full_seen = 1;
                chk("burst_accepted_at_full", idx, 5);
                chk("burst_ready_at_full", int'(rdy0), 0);
            end else if (full_seen && !coll_seen && m_cnt[0] == DEPTH - 1) begin
                coll_seen = 1;
                chk("collision_no_write", idx, 5);
                chk("collision_level", int'(lvl0), 3);
                chk("collision_ready_rise", int'(rdy0), 1);
            end
        end
        val0 = 1'b0;
        chk("burst_all_accepted", idx, 6);
        chk("burst_full_seen", int'(full_seen), 1);
        chk("burst_collision_seen", int'(coll_seen), 1);
        g = 0;
        while (rx_n[0] < 6 && g < 3000) begin
            tick();
            g++;
        end
        chk("burst_rx_count", rx_n[0], 6);
        for (int j = 0; j < 6; j++) chk($sformatf("burst_rx_byte%0d", j), rx_log[0][j], words[j]);
        for (int j = 1; j < 6; j++) chk($sformatf("burst_gap%0d", j), rx_gap[0][j], 16 * FL0);
        wait_idle();

        // Two stop bits, seven data bits: 0x7F then a queued 0x01.
        rx_n[1] = 0;
        din1 = 7'h7F;
        val1 = 1'b1;
        tick();
        din1 = 7'h01;
        tick();
        val1 = 1'b0;
        g = 0;
        while (rx_n[1] < 2 && g < 1000) begin
            tick();
            g++;
        end
        chk("stop2_rx_count", rx_n[1], 2);
        chk("stop2_byte0", rx_log[1][0], 8'h7F);
        chk("stop2_byte1", rx_log[1][1], 8'h01);
        chk("stop2_gap", rx_gap[1][1], 16 * FL1);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        for (int po = 0; po < 2; po++) begin
            rx_n[0] = 0;
            din0 = 8'h07;
            par0 = po[0];
            val0 = 1'b1;
            tick();
            val0 = 1'b0;
            g = 0;
            while (rx_n[0] < 1 && g < 400) begin
                tick();
                g++;
            end
            chk($sformatf("parity_0x07_odd%0d", po), rx_par[0], 1 - po);
            wait_idle();
        end
        par0 = 1'b0;
`endif

        // Reset during data bit 3 with two words queued.
        din0 = 8'h11;
        val0 = 1'b1;
        tick();
        din0 = 8'h22;
        tick();
        din0 = 8'h33;
        tick();
        val0 = 1'b0;
        g = 0;
        while (rx_cnt[0] != 8 + 16 * 4 && g < 300) begin
            tick();
            g++;
        end
        chk("midframe_reached", rx_cnt[0], 8 + 16 * 4);
        chk("midframe_queued", m_cnt[0], 2);
        rst_n = 1'b0;
        #1;
        reset_literals("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("post_reset_idle_tx", int'(tx0), 1);
        end

        // Randomized traffic: dense first half to keep the FIFO full, sparse second half.
        for (int n = 0; n < 2500; n++) begin
            din0 = 8'($urandom);
            din1 = 7'($urandom);
            par0 = 1'($urandom);
            par1 = 1'($urandom);
            if (n < 1250) begin
                val0 = ($urandom_range(0, 3) != 0);
                val1 = ($urandom_range(0, 3) != 0);
            end else begin
                val0 = ($urandom_range(0, 7) == 0);
                val1 = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        val0 = 1'b0;
        val1 = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
